pulse_generator_scheduler: RTL

- Sequences one pulse generator channel from its configuration registers (enable, start date/time, high width, period) and the system time base.
- Arms on enable and waits for the programmed start time, aligned to the PPS strobe.
- Then emits a periodic pulse train counted in microsecond ticks.
- Sits between the channel's register block and the output pin; one instance per channel.

---
 rtl/pulse_generator_scheduler.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_generator_scheduler.sv
// rtl/pulse_generator_scheduler.sv - single-channel pulse train sequencer (arm, PPS-aligned start, periodic pulses)
//
// Purpose:
//   Arms on a rising edge of the channel enable bit after checking the
//   width/period configuration. It then waits for a PPS strobe whose
//   current time has reached the latched start time. After that it emits
//   a periodic pulse train that advances one step per microsecond tick.
//
// Optional build macro:
//   PG_ONE_SHOT_EN - when defined, i_pulse_enable[1] (latched at arm time)
//                    selects one-shot mode: a single period, then DONE.
//                    When undefined, bit 1 is ignored and o_done is tied 0.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_us_tick      one-cycle strobe per microsecond
//   i_pps          one-cycle strobe per second boundary
//   i_cur_time     {year_h, year_l, month, day, hour, minutes, seconds}, valid with i_pps
//   i_pulse_enable enable register (bit ENA_BIT enables, bit 1 one-shot if built in)
//   i_usr_time     programmed start time, same packing as i_cur_time
//   i_width_high   high time in microseconds
//   i_width_period period in microseconds
//   o_pulse        registered pulse output
//   o_state        0=IDLE, 1=ARMED, 2=RUNNING, 3=DONE
//   o_cfg_err      sticky configuration error flag
//   o_done         one-shot completion flag

module pulse_generator_scheduler #(
    parameter int CNT_WIDTH = 24,
    parameter int ENA_BIT   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_us_tick,
    input  logic                 i_pps,
    input  logic [55:0]          i_cur_time,
    input  logic [7:0]           i_pulse_enable,
    input  logic [55:0]          i_usr_time,
    input  logic [CNT_WIDTH-1:0] i_width_high,
    input  logic [CNT_WIDTH-1:0] i_width_period,
    output logic                 o_pulse,
    output logic [1:0]           o_state,
    output logic                 o_cfg_err,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q;
    state_t                 state_d;

    logic                   ena_q;
    logic [55:0]            usr_q;
    logic [CNT_WIDTH-1:0]   high_q;
    logic [CNT_WIDTH-1:0]   period_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   pulse_q;
    logic                   err_q;

    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   pulse_d;
    logic                   err_d;
    logic                   latch_en;

    logic                   ena;
    logic                   ena_rise;
    logic                   cfg_bad;
    logic                   start_hit;
    logic                   cnt_last;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   one_shot;

    // Only the enable bit (and the one-shot bit, when built in) matter.
    logic                   unused_ena_bits;
    assign unused_ena_bits = ^i_pulse_enable;

    assign ena       = i_pulse_enable[ENA_BIT];
    assign ena_rise  = ena & ~ena_q;
    // The check runs on the live inputs in the same cycle they are latched,
    // so it sees exactly the values that will be stored.
    assign cfg_bad   = (i_width_high == '0) || (i_width_period <= i_width_high);
    assign start_hit = i_pps && (i_cur_time >= usr_q);
    assign cnt_last  = (cnt_q == period_q - CNT_ONE);
    assign cnt_inc   = cnt_last ? '0 : cnt_q + CNT_ONE;

`ifdef PG_ONE_SHOT_EN
    logic one_shot_q;
    logic done_q;
    logic done_d;
    assign one_shot = one_shot_q;
    assign o_done   = done_q;
`else
    assign one_shot = 1'b0;
    assign o_done   = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a low enable bit overrides every other event.
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ena_rise && !cfg_bad) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (start_hit) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (i_us_tick && cnt_last && one_shot) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        pulse_d  = pulse_q;
        err_d    = err_q;
        latch_en = 1'b0;
`ifdef PG_ONE_SHOT_EN
        done_d   = done_q;
`endif
        if (!ena) begin
            cnt_d   = '0;
            pulse_d = 1'b0;
`ifdef PG_ONE_SHOT_EN
            done_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ena_rise) begin
                        latch_en = 1'b1;
                        err_d    = cfg_bad;
                    end
                end
                ST_ARMED: begin
                    // A tick arriving with the starting PPS is not counted.
                    if (start_hit) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (i_us_tick) begin
                        if (cnt_last && one_shot) begin
                            cnt_d   = '0;
                            pulse_d = 1'b0;
`ifdef PG_ONE_SHOT_EN
                            done_d  = 1'b1;
`endif
                        end else begin
                            cnt_d   = cnt_inc;
                            pulse_d = (cnt_inc < high_q);
                        end
                    end
                end
                default: begin
                    pulse_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ena_q    <= 1'b0;
            usr_q    <= '0;
            high_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ena_q   <= ena;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
            if (latch_en) begin
                usr_q    <= i_usr_time;
                high_q   <= i_width_high;
                period_q <= i_width_period;
            end
        end
    end

`ifdef PG_ONE_SHOT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            one_shot_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_d;
            if (latch_en) begin
                one_shot_q <= i_pulse_enable[1];
            end
        end
    end
`endif

    assign o_pulse   = pulse_q;
    assign o_state   = state_q;
    assign o_cfg_err = err_q;

endmodule
